pwq_activation: RTL and testbench

PWQ_ACTIVATION -- requirements
Module: pwq_activation

---
 rtl/pwq_activation.sv | 163 ++++++++++++++++
 tb/tb_pwq_activation.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwq_activation.sv
// pwq_activation: piecewise-quadratic sigmoid/tanh approximation over a
// signed fixed-point word (QN integer bits, QM fraction bits, 1.0 = 2^QM).
// The range [-2^XLOG, 2^XLOG) is split into 2^SEGLOG equal segments per
// function. Each segment evaluates y = (p2*x + p1)*x + p0 in Horner form.
// Inputs outside the range bypass the polynomial and take the asymptote.
// Four pipeline stages are stalled together by output back-pressure.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   in_valid/in_ready     input handshake; in_data = x, in_mode 0 sigmoid / 1 tanh
//   out_valid/out_ready   output handshake; out_data = y
//   coef_we/addr/data     coefficient table write, addr = {bank, seg, k}
//                         (k = 0 p0, 1 p1, 2 p2, 3 ignored)
module pwq_activation #(
  parameter int unsigned QN     = 6,
  parameter int unsigned QM     = 11,
  parameter int unsigned SEGLOG = 3,
  parameter int unsigned XLOG   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [QN+QM:0]      in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [QN+QM:0]      out_data,
  input  logic                coef_we,
  input  logic [SEGLOG+2:0]   coef_addr,
  input  logic [QN+QM:0]      coef_data
);

  localparam int unsigned W    = QN + QM + 1;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned NENT = 2 * (1 << SEGLOG);
  localparam int unsigned AW   = SEGLOG + 1;
  localparam int unsigned SH   = XLOG + 1 - SEGLOG + QM;
  localparam int unsigned HI   = XLOG + QM + 1;

  localparam logic [W-1:0]  ONE   = W'(1) << QM;
  localparam logic [W-1:0]  MONE  = ~ONE + W'(1);
  localparam logic [W:0]    OFS   = (W + 1)'(1) << (XLOG + QM);
  localparam logic [PW-1:0] RHALF = PW'(1) << (QM - 1);
  localparam logic [W-1:0]  SMAX  = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]  SMIN  = {1'b1, {(W - 1){1'b0}}};

  // Clamp a wide two's-complement value into the W-bit signed range.
  function automatic logic [W-1:0] sat_w(input logic [PW-1:0] v);
    if ((&v[PW-1:W-1]) || !(|v[PW-1:W-1])) sat_w = v[W-1:0];
    else if (v[PW-1])                      sat_w = SMIN;
    else                                   sat_w = SMAX;
  endfunction

  // Full-width signed product, round half up at bit QM, then clamp.
  function automatic logic [W-1:0] mul_rs(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] p;
    p = PW'($signed(a)) * PW'($signed(b)) + RHALF;
    mul_rs = sat_w(PW'($signed(p) >>> QM));
  endfunction

  // Signed sum with clamp.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    sat_add = sat_w(PW'($signed(a)) + PW'($signed(b)));
  endfunction

  logic [W-1:0] tp0 [NENT];
  logic [W-1:0] tp1 [NENT];
  logic [W-1:0] tp2 [NENT];

  logic          adv;
  logic [W:0]    xofs;
  logic          lo, hi;
  logic [SEGLOG-1:0] idx;
  logic [AW-1:0] ridx;
  logic [AW-1:0] waddr;

  // Stage registers
  logic          v1, m1, lo1, hi1;
  logic [W-1:0]  x1, c2_1, c1_1, c0_1;
  logic          v2, m2, lo2, hi2;
  logic [W-1:0]  x2, t2, c1_2, c0_2;
  logic          v3, m3, lo3, hi3;
  logic [W-1:0]  t3, c0_3;

  // Whole pipeline advances unless a held result is being refused.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Offsetting x by 2^XLOG maps the approximation range onto [0, 2^(XLOG+1)),
  // so the sign bit flags underflow and any bit at HI or above flags overflow.
  assign xofs  = {in_data[W-1], in_data} + OFS;
  assign lo    = xofs[W];
  assign hi    = !xofs[W] && (|xofs[W-1:HI]);
  assign idx   = SEGLOG'(xofs >> SH);
  assign ridx  = {in_mode, idx};
  assign waddr = coef_addr[SEGLOG+2:2];

  // Coefficient table; writes are independent of pipeline stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NENT; i++) begin
        tp0[i] <= '0;
        tp1[i] <= '0;
        tp2[i] <= '0;
      end
    end else if (coef_we) begin
      case (coef_addr[1:0])
        2'd0:    tp0[waddr] <= coef_data;
        2'd1:    tp1[waddr] <= coef_data;
        2'd2:    tp2[waddr] <= coef_data;
        default: ;
      endcase
    end
  end

  // Four-stage Horner pipeline; coefficients are latched at S1 and ride along.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0; m1 <= 1'b0; lo1 <= 1'b0; hi1 <= 1'b0;
      x1 <= '0; c2_1 <= '0; c1_1 <= '0; c0_1 <= '0;
      v2 <= 1'b0; m2 <= 1'b0; lo2 <= 1'b0; hi2 <= 1'b0;
      x2 <= '0; t2 <= '0; c1_2 <= '0; c0_2 <= '0;
      v3 <= 1'b0; m3 <= 1'b0; lo3 <= 1'b0; hi3 <= 1'b0;
      t3 <= '0; c0_3 <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      v1   <= in_valid;
      m1   <= in_mode;
      lo1  <= lo;
      hi1  <= hi;
      x1   <= in_data;
      c2_1 <= tp2[ridx];
      c1_1 <= tp1[ridx];
      c0_1 <= tp0[ridx];

      v2   <= v1;
      m2   <= m1;
      lo2  <= lo1;
      hi2  <= hi1;
      x2   <= x1;
      t2   <= mul_rs(c2_1, x1);
      c1_2 <= c1_1;
      c0_2 <= c0_1;

      v3   <= v2;
      m3   <= m2;
      lo3  <= lo2;
      hi3  <= hi2;
      t3   <= mul_rs(sat_add(t2, c1_2), x2);
      c0_3 <= c0_2;

      out_valid <= v3;
      if (v3) begin
        if (lo3)      out_data <= m3 ? MONE : '0;
        else if (hi3) out_data <= ONE;
        else          out_data <= sat_add(t3, c0_3);
      end
    end
  end

endmodule

// File: tb/tb_pwq_activation.sv
// Bench for pwq_activation at QN=6, QM=11, SEGLOG=3, XLOG=3.
module tb_pwq_activation;

  localparam int     W    = 18;
  localparam longint SMAX = 131071;
  localparam longint SMIN = -131072;

  logic                clk, reset, in_valid, in_ready, in_mode;
  logic                out_valid, out_ready, coef_we;
  logic signed [W-1:0] in_data, out_data, coef_data;
  logic [5:0]          coef_addr;

  pwq_activation #(.QN(6), .QM(11), .SEGLOG(3), .XLOG(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint data; int cyc; } exp_t;

  exp_t   sb[$];
  longint ctab [2][8][3];
  int     npass, nfail, ntot, cyc, last_lat, npop;
  longint last_out;
  bit     accepted;

  task automatic check(input string tag, input longint obs, input longint exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint msat(input longint v);
    return (v > SMAX) ? SMAX : ((v < SMIN) ? SMIN : v);
  endfunction

  function automatic longint mrs(input longint p);
    return msat((p + 1024) >>> 11);
  endfunction

  // Reference: segment select, Horner with rounding and saturation, bypass.
  function automatic longint mdl(input longint x, input bit m);
    int     s;
    longint t;
    if (x < -16384) return m ? -2048 : 0;
    if (x >= 16384) return 2048;
    s = int'((x + 16384) / 4096);
    t = mrs(ctab[m][s][2] * x);
    t = msat(t + ctab[m][s][1]);
    t = mrs(t * x);
    return msat(t + ctab[m][s][0]);
  endfunction

  // One clock: observe handshakes before the edge, then advance.
  task automatic step();
    exp_t e;
    #1;
    accepted = 1'b0;
    if (reset) begin
      if (out_valid && out_ready) begin
        npop++;
        check("sb_nonempty", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_data", longint'(out_data), e.data);
          last_lat = cyc - e.cyc;
          last_out = longint'(out_data);
        end
      end
      if (in_valid && in_ready) begin
        e.data = mdl(longint'(in_data), in_mode);
        e.cyc  = cyc;
        sb.push_back(e);
        accepted = 1'b1;
      end
      if (coef_we && coef_addr[1:0] != 2'd3)
        ctab[coef_addr[5]][coef_addr[4:2]][coef_addr[1:0]] = longint'(coef_data);
    end else begin
      sb.delete();
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < 8; s++)
          for (int k = 0; k < 3; k++) ctab[b][s][k] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input longint x, input bit m);
    in_valid = 1'b1;
    in_data  = W'(x);
    in_mode  = m;
    for (int k = 0; k < 20; k++) begin
      step();
      if (accepted) break;
    end
    check("accept", longint'(accepted), 1);
    in_valid = 1'b0;
  endtask

  task automatic wr(input int b, input int s, input int k, input longint v);
    coef_we   = 1'b1;
    coef_addr = {1'(b), 3'(s), 2'(k)};
    coef_data = W'(v);
    step();
    coef_we   = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() > 0; k++) step();
    check("drain_empty", longint'(sb.size()), 0);
  endtask

  task automatic one(input longint x, input bit m, input longint expv, input string tag);
    send(x, m);
    drain();
    check(tag, last_out, expv);
  endtask

  longint xs [8];
  bit     ms [8];
  longint held;
  int     sent, it, pops0;

  initial begin
    npass = 0; nfail = 0; ntot = 0; cyc = 0; last_lat = 0; npop = 0; last_out = 0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;

    // Reset and idle state
    step(); step();
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    out_ready = 1'b1;

    // Constant p0 in every bank-0 segment; k=3 write must be ignored
    for (int s = 0; s < 8; s++) wr(0, s, 0, 1024);
    wr(0, 0, 3, 777);
    one(0, 1'b0, 1024, "p0_const");
    check("latency", longint'(last_lat), 4);
    one(-16384, 1'b0, 1024, "seg0_lo_edge");
    one(16383, 1'b0, 1024, "seg7_hi_edge");
    one(0, 1'b1, 0, "bank1_zero");

    // Squaring in segment 4, plus rounding behaviour
    wr(0, 4, 2, 2048);
    wr(0, 4, 0, 0);
    one(3072, 1'b0, 4608, "square_1p5");
    one(32, 1'b0, 1, "round_half_pos");
    wr(0, 3, 1, 1024);
    wr(0, 3, 0, 0);
    one(-1, 1'b0, 0, "round_half_neg");
    one(-3, 1'b0, -1, "round_neg_1p5");

    // Out-of-range bypass
    one(16384, 1'b0, 2048, "bypass_hi_sig");
    one(-18432, 1'b1, -2048, "bypass_lo_tanh");
    one(-16385, 1'b0, 0, "bypass_lo_sig");
    one(16384, 1'b1, 2048, "bypass_hi_tanh");

    // Saturation
    wr(0, 7, 2, 4096);
    wr(0, 7, 0, 0);
    one(14336, 1'b0, 131071, "sat_pos");

    // In-flight sample keeps its coefficients across a table write
    send(3072, 1'b0);
    wr(0, 4, 2, 4096);
    send(3072, 1'b0);
    drain();
    check("coef_update", last_out, 9216);

    // Random table and samples
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < 8; s++)
        for (int k = 0; k < 3; k++)
          wr(b, s, k, longint'($urandom_range(0, 8191)) - 4096);
    for (int n = 0; n < 24; n++)
      send(longint'($urandom_range(0, 40000)) - 20000, 1'($urandom_range(0, 1)));
    drain();

    // Back-to-back stream with a 3-cycle output stall
    for (int n = 0; n < 8; n++) begin
      xs[n] = longint'($urandom_range(0, 32767)) - 16384;
      ms[n] = 1'($urandom_range(0, 1));
    end
    pops0 = npop; sent = 0; it = 0; held = 0;
    while (sent < 8 && it < 40) begin
      out_ready = !(it >= 5 && it <= 7);
      in_valid  = 1'b1;
      in_data   = W'(xs[sent]);
      in_mode   = ms[sent];
      #1;
      if (it >= 5 && it <= 7) begin
        check("stall_in_ready", longint'(in_ready), 0);
        check("stall_out_valid", longint'(out_valid), 1);
        if (it == 5) held = longint'(out_data);
        else check("stall_hold", longint'(out_data), held);
      end else begin
        check("run_in_ready", longint'(in_ready), 1);
      end
      step();
      if (accepted) sent++;
      it++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("stream_count", longint'(npop - pops0), 8);

    // Reset with samples in flight
    wr(0, 4, 0, 500);
    send(100, 1'b0);
    send(200, 1'b1);
    send(-300, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_data", longint'(out_data), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("midrst_quiet", longint'(out_valid), 0);
    end
    one(0, 1'b0, 0, "table_cleared");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", npass, ntot);
    $fatal(1, "watchdog");
  end

endmodule
